// File: rtl/otter_intr_pkg.sv
// Shared types and register map for the OTTER interrupt controller.
package otter_intr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intr_state_t;

  localparam logic [1:0] INTR_ENABLE  = 2'd0;
  localparam logic [1:0] INTR_PENDING = 2'd1;
  localparam logic [1:0] INTR_CLAIM   = 2'd2;
  localparam logic [1:0] INTR_STATUS  = 2'd3;

  localparam int unsigned CLAIM_INSVC_BIT = 31;
  localparam int unsigned STATUS_ERR_BIT  = 2;

endpackage

// File: rtl/intr_sync_edge.sv
// Synchronizes one asynchronous interrupt line and emits a registered one-cycle
// pulse on each rising edge.
module intr_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic irq_async,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_async};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/otter_intr_ctrl.sv
// Request-side interrupt controller: latches edge events as pending, arbitrates
// lowest-index-first and runs the INTR / INT_TAKEN / MRET handshake with the MCU.
module otter_intr_ctrl
  import otter_intr_pkg::*;
#(
  parameter int unsigned N_SRC       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_SRC-1:0] IRQ_IN,
  input  logic             CSR_MSTATUS,
  input  logic             INT_TAKEN,
  input  logic             CSR_MRET,
  output logic             INTR,
  input  logic             IO_SEL,
  input  logic [1:0]       IO_ADDR,
  input  logic             IO_WR,
  input  logic [31:0]      IO_WD,
  output logic [31:0]      IO_RD
);

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] enable_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] claim_mask;
  logic [N_SRC-1:0] w1c_mask;
  logic [N_SRC-1:0] take_mask;
  logic [3:0]       claim_id_q;
  logic [3:0]       win_id;
  intr_state_t      state_q;
  logic             intr_q;
  logic             err_q, err_d;
  logic             wr_en;
  logic             take;
  logic             claim_active;
  logic             unused_wd;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    intr_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .CLK      (CLK),
      .RST      (RST),
      .irq_async(IRQ_IN[i]),
      .rise     (rise[i])
    );
  end

  assign unused_wd    = ^IO_WD;
  assign wr_en        = IO_SEL & IO_WR;
  assign take         = (state_q == REQ) & INT_TAKEN;
  assign active       = pending_q & enable_q;
  assign claim_mask   = N_SRC'(1) << claim_id_q;
  assign claim_active = |(active & claim_mask);
  assign w1c_mask     = (wr_en && IO_ADDR == INTR_PENDING) ? IO_WD[N_SRC-1:0] : '0;
  assign take_mask    = take ? claim_mask : '0;
  // A fresh edge beats any clear landing in the same cycle.
  assign pending_d    = (pending_q & ~(w1c_mask | take_mask)) | rise;

  always_comb begin
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) win_id = 4'(i);
    end
  end

  always_comb begin
    err_d = err_q;
    if (wr_en && IO_ADDR == INTR_STATUS && IO_WD[STATUS_ERR_BIT]) err_d = 1'b0;
    if ((INT_TAKEN && state_q != REQ) || (CSR_MRET && state_q != SERVICE)) err_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      enable_q  <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (wr_en && IO_ADDR == INTR_ENABLE) enable_q <= IO_WD[N_SRC-1:0];
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      claim_id_q <= '0;
      intr_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|active && CSR_MSTATUS) begin
            claim_id_q <= win_id;
            state_q    <= REQ;
            intr_q     <= 1'b1;
          end
        end
        REQ: begin
          if (INT_TAKEN) begin
            state_q <= SERVICE;
            intr_q  <= 1'b0;
          end else if (!claim_active || !CSR_MSTATUS) begin
            state_q <= IDLE;
            intr_q  <= 1'b0;
          end
        end
        SERVICE: begin
          intr_q <= 1'b0;
          if (CSR_MRET) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          intr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign INTR = intr_q;

  always_comb begin
    IO_RD = '0;
    unique case (IO_ADDR)
      INTR_ENABLE:  IO_RD = 32'(enable_q);
      INTR_PENDING: IO_RD = 32'(pending_q);
      INTR_CLAIM: begin
        IO_RD[3:0]             = claim_id_q;
        IO_RD[CLAIM_INSVC_BIT] = (state_q == SERVICE);
      end
      INTR_STATUS: begin
        IO_RD[1:0]            = state_q;
        IO_RD[STATUS_ERR_BIT] = err_q;
      end
      default: IO_RD = '0;
    endcase
  end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Directed scoreboard bench for otter_intr_ctrl.
`timescale 1ns/100ps
module tb_otter_intr_ctrl;

  localparam int N = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  IRQ_IN = '0;
  logic          CSR_MSTATUS = 1'b0;
  logic          INT_TAKEN = 1'b0;
  logic          CSR_MRET = 1'b0;
  logic          INTR;
  logic          IO_SEL = 1'b0;
  logic [1:0]    IO_ADDR = 2'd0;
  logic          IO_WR = 1'b0;
  logic [31:0]   IO_WD = '0;
  logic [31:0]   IO_RD;

  otter_intr_ctrl #(.N_SRC(N), .SYNC_STAGES(2)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IRQ_IN     (IRQ_IN),
    .CSR_MSTATUS(CSR_MSTATUS),
    .INT_TAKEN  (INT_TAKEN),
    .CSR_MRET   (CSR_MRET),
    .INTR       (INTR),
    .IO_SEL     (IO_SEL),
    .IO_ADDR    (IO_ADDR),
    .IO_WR      (IO_WR),
    .IO_WD      (IO_WD),
    .IO_RD      (IO_RD)
  );

  always #20 CLK = ~CLK;

  // kind 0..3 = register offset read back, kind 4 = INTR pin
  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input string tag, input int kind, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.kind == 4) begin
        obs = {31'd0, INTR};
      end else begin
        IO_ADDR = 2'(e.kind);
        #1;
        obs = IO_RD;
      end
      total++;
      assert (obs === e.exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    IO_SEL = 1'b1; IO_WR = 1'b1; IO_ADDR = addr; IO_WD = data;
    tick(1);
    IO_SEL = 1'b0; IO_WR = 1'b0; IO_WD = '0;
  endtask

  task automatic pulse_taken();
    INT_TAKEN = 1'b1; tick(1); INT_TAKEN = 1'b0;
  endtask

  task automatic pulse_mret();
    CSR_MRET = 1'b1; tick(1); CSR_MRET = 1'b0;
  endtask

  initial begin
    // reset state
    tick(2);
    RST = 1'b0;
    push("rst_enable", 0, 32'h0);
    push("rst_pending", 1, 32'h0);
    push("rst_claim", 2, 32'h0);
    push("rst_status", 3, 32'h0);
    push("rst_intr", 4, 32'h0);
    drain();

    // single source, latency check
    wr(2'd0, 32'h01);
    push("en_rw", 0, 32'h01);
    drain();
    CSR_MSTATUS = 1'b1;
    IRQ_IN[0] = 1'b1;
    tick(3);                       // after edge 2
    push("lat_pend_e2", 1, 32'h00);
    drain();
    tick(1);                       // edge 3
    push("lat_pend_e3", 1, 32'h01);
    push("lat_intr_e3", 4, 32'h0);
    drain();
    tick(1);                       // edge 4
    push("lat_intr_e4", 4, 32'h1);
    push("req_status", 3, 32'h1);
    drain();
    pulse_taken();
    push("take_intr", 4, 32'h0);
    push("take_pend", 1, 32'h0);
    push("take_claim", 2, 32'h8000_0000);
    push("take_status", 3, 32'h2);
    drain();
    pulse_mret();
    push("mret_status", 3, 32'h0);
    drain();
    IRQ_IN = '0;
    tick(4);

    // priority between lines 5 and 2
    wr(2'd0, 32'hFF);
    IRQ_IN = 8'h24;
    tick(5);
    push("prio_intr", 4, 32'h1);
    push("prio_claim", 2, 32'h2);
    push("prio_pend", 1, 32'h24);
    drain();
    pulse_taken();
    push("prio_take_pend", 1, 32'h20);
    push("prio_take_claim", 2, 32'h8000_0002);
    drain();
    pulse_mret();
    push("prio_mret_intr", 4, 32'h0);
    drain();
    tick(1);
    push("prio_rearm_intr", 4, 32'h1);
    push("prio_rearm_claim", 2, 32'h5);
    drain();
    pulse_taken();

    // edge while in SERVICE accumulates, held until after MRET
    IRQ_IN = 8'h26;
    tick(5);
    push("svc_pend", 1, 32'h02);
    push("svc_intr", 4, 32'h0);
    push("svc_status", 3, 32'h2);
    drain();
    pulse_mret();
    push("svc_mret_intr", 4, 32'h0);
    drain();
    tick(1);
    push("svc_rearm_intr", 4, 32'h1);
    push("svc_rearm_claim", 2, 32'h1);
    drain();

    // W1C withdraws request without INT_TAKEN
    wr(2'd1, 32'h02);
    push("w1c_pend", 1, 32'h00);
    push("w1c_intr_hold", 4, 32'h1);
    drain();
    tick(1);
    push("w1c_intr", 4, 32'h0);
    push("w1c_status", 3, 32'h0);
    drain();

    // MIE gating
    CSR_MSTATUS = 1'b0;
    wr(2'd0, 32'h04);
    IRQ_IN = '0;
    tick(4);
    IRQ_IN = 8'h04;
    tick(5);
    push("mie_pend", 1, 32'h04);
    push("mie_intr", 4, 32'h0);
    drain();
    tick(2);
    push("mie_intr_hold", 4, 32'h0);
    drain();
    CSR_MSTATUS = 1'b1;
    tick(1);
    push("mie_on_intr", 4, 32'h1);
    push("mie_on_claim", 2, 32'h2);
    drain();
    CSR_MSTATUS = 1'b0;
    tick(1);
    push("mie_off_intr", 4, 32'h0);
    push("mie_off_status", 3, 32'h0);
    drain();

    // protocol errors
    pulse_taken();
    push("err_taken", 3, 32'h4);
    push("err_claim", 2, 32'h2);
    drain();
    wr(2'd3, 32'h4);
    push("err_clear", 3, 32'h0);
    drain();
    pulse_mret();
    push("err_mret", 3, 32'h4);
    drain();

    // reset from SERVICE
    CSR_MSTATUS = 1'b1;
    tick(1);
    push("pre_rst_intr", 4, 32'h1);
    drain();
    pulse_taken();
    push("pre_rst_status", 3, 32'h6);
    drain();
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    push("mid_rst_enable", 0, 32'h0);
    push("mid_rst_pend", 1, 32'h0);
    push("mid_rst_claim", 2, 32'h0);
    push("mid_rst_status", 3, 32'h0);
    push("mid_rst_intr", 4, 32'h0);
    drain();
    tick(4);
    push("high_at_rst_pend", 1, 32'h04);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
